// File: rtl/ctrl_pkg.sv
// Shared definitions for the control_sequencer slice: opcodes, ring modes,
// T-step indices, control-word bit positions and the opcode classifier.
// Optional feature macro: CTRL_FLAGS_EN (carry/zero flags and JC/JZ).
package ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    MODE_6  = 2'b00,
    MODE_10 = 2'b01,
    MODE_15 = 2'b10
  } ring_mode_e;

  localparam int unsigned TS0 = 0;
  localparam int unsigned TS1 = 1;
  localparam int unsigned TS2 = 2;
  localparam int unsigned TS3 = 3;
  localparam int unsigned TS4 = 4;
  localparam int unsigned TS5 = 5;
  localparam int unsigned TS6 = 6;
  localparam int unsigned TS7 = 7;
  localparam int unsigned TS8 = 8;

  // Bus control lines followed by internal register-load strobes
  localparam int unsigned CW_PC_OUT   = 0;
  localparam int unsigned CW_ADDR_OUT = 1;
  localparam int unsigned CW_MAR_IN   = 2;
  localparam int unsigned CW_RAM_OUT  = 3;
  localparam int unsigned CW_RAM_IN   = 4;
  localparam int unsigned CW_IR_IN    = 5;
  localparam int unsigned CW_A_IN     = 6;
  localparam int unsigned CW_A_OUT    = 7;
  localparam int unsigned CW_B_IN     = 8;
  localparam int unsigned CW_ALU_OUT  = 9;
  localparam int unsigned CW_ALU_SUB  = 10;
  localparam int unsigned CW_OUT_IN   = 11;
  localparam int unsigned CW_PC_COUNT = 12;
  localparam int unsigned CW_PC_LOAD  = 13;
  localparam int unsigned CW_LD_LO    = 14;
  localparam int unsigned CW_LD_HI    = 15;
  localparam int unsigned CW_LD_FLAGS = 16;
  localparam int unsigned CW_HALT     = 17;
  localparam int unsigned CW_W        = 18;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_LDA, CLS_ADD, CLS_SUB, CLS_STA, CLS_LDI,
    CLS_JMP, CLS_JC, CLS_JZ, CLS_OUT, CLS_HLT
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    op_class_e c;
    c = CLS_NOP;
    case (op)
      OP_LDA: c = CLS_LDA;
      OP_ADD: c = CLS_ADD;
      OP_SUB: c = CLS_SUB;
      OP_STA: c = CLS_STA;
      OP_LDI: c = CLS_LDI;
      OP_JMP: c = CLS_JMP;
`ifdef CTRL_FLAGS_EN
      OP_JC:  c = CLS_JC;
      OP_JZ:  c = CLS_JZ;
`endif
      OP_OUT: c = CLS_OUT;
      OP_HLT: c = CLS_HLT;
      default: c = CLS_NOP;
    endcase
    return c;
  endfunction

  function automatic ring_mode_e class_mode(input op_class_e c);
    ring_mode_e m;
    case (c)
      CLS_LDI: m = MODE_10;
      CLS_LDA, CLS_ADD, CLS_SUB, CLS_STA,
      CLS_JMP, CLS_JC, CLS_JZ: m = MODE_15;
      default: m = MODE_6;
    endcase
    return m;
  endfunction

  function automatic logic is_onehot(input logic [14:0] v);
    return (v != '0) && ((v & (v - 15'd1)) == '0);
  endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// Purely combinational decode of (opcode, T-step, flags) into a control
// word and ring-counter mode. Assumes t_state_i is one-hot; gating is done
// by the parent.
module ctrl_step_decode
  import ctrl_pkg::*;
(
  input  logic [3:0]      opcode_i,
  input  logic [14:0]     t_state_i,
  input  logic            carry_i,
  input  logic            zero_i,
  output logic [CW_W-1:0] cw_o,
  output ring_mode_e      mode_o
);

  op_class_e cls;
  logic      long_op;
  logic      unused_steps;

  // T9..T14 are idle for every instruction
  assign unused_steps = |t_state_i[14:9];

  // Per-step control word for the current instruction class
  always_comb begin
    cls     = classify(opcode_i);
    mode_o  = class_mode(cls);
    long_op = (mode_o == MODE_15);
    cw_o    = '0;

    if (t_state_i[TS0]) begin
      cw_o[CW_PC_OUT] = 1'b1;
      cw_o[CW_MAR_IN] = 1'b1;
    end
    if (t_state_i[TS1]) begin
      cw_o[CW_RAM_OUT]  = 1'b1;
      cw_o[CW_IR_IN]    = 1'b1;
      cw_o[CW_PC_COUNT] = 1'b1;
    end
    if (t_state_i[TS2]) begin
      if (cls == CLS_OUT) begin
        cw_o[CW_A_OUT]  = 1'b1;
        cw_o[CW_OUT_IN] = 1'b1;
      end
      if (cls == CLS_HLT) cw_o[CW_HALT] = 1'b1;
      if (cls == CLS_LDI || long_op) begin
        cw_o[CW_PC_OUT] = 1'b1;
        cw_o[CW_MAR_IN] = 1'b1;
      end
    end
    if (t_state_i[TS3]) begin
      if (cls == CLS_LDI) begin
        cw_o[CW_RAM_OUT]  = 1'b1;
        cw_o[CW_A_IN]     = 1'b1;
        cw_o[CW_PC_COUNT] = 1'b1;
      end
      if (long_op) begin
        cw_o[CW_RAM_OUT]  = 1'b1;
        cw_o[CW_PC_COUNT] = 1'b1;
        cw_o[CW_LD_LO]    = 1'b1;
      end
    end
    if (t_state_i[TS4] && long_op) begin
      cw_o[CW_PC_OUT] = 1'b1;
      cw_o[CW_MAR_IN] = 1'b1;
    end
    if (t_state_i[TS5] && long_op) begin
      cw_o[CW_RAM_OUT]  = 1'b1;
      cw_o[CW_PC_COUNT] = 1'b1;
      cw_o[CW_LD_HI]    = 1'b1;
    end
    if (t_state_i[TS6]) begin
      case (cls)
        CLS_LDA, CLS_ADD, CLS_SUB, CLS_STA: begin
          cw_o[CW_ADDR_OUT] = 1'b1;
          cw_o[CW_MAR_IN]   = 1'b1;
        end
        CLS_JMP: cw_o[CW_PC_LOAD] = 1'b1;
        CLS_JC:  cw_o[CW_PC_LOAD] = carry_i;
        CLS_JZ:  cw_o[CW_PC_LOAD] = zero_i;
        default: ;
      endcase
    end
    if (t_state_i[TS7]) begin
      case (cls)
        CLS_LDA: begin
          cw_o[CW_RAM_OUT] = 1'b1;
          cw_o[CW_A_IN]    = 1'b1;
        end
        CLS_ADD, CLS_SUB: begin
          cw_o[CW_RAM_OUT] = 1'b1;
          cw_o[CW_B_IN]    = 1'b1;
        end
        CLS_STA: begin
          cw_o[CW_A_OUT]  = 1'b1;
          cw_o[CW_RAM_IN] = 1'b1;
        end
        default: ;
      endcase
    end
    if (t_state_i[TS8] && (cls == CLS_ADD || cls == CLS_SUB)) begin
      cw_o[CW_ALU_OUT]  = 1'b1;
      cw_o[CW_A_IN]     = 1'b1;
      cw_o[CW_LD_FLAGS] = 1'b1;
      cw_o[CW_ALU_SUB]  = (cls == CLS_SUB);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction control unit for the 8-bit CPU: holds IR, operand address,
// flags and halt state; gates decoded controls on halt/reset/one-hot.
// Optional feature macro: CTRL_FLAGS_EN (carry/zero flags and JC/JZ).
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clear_n,
  input  logic [14:0] t_state,
  input  logic [7:0]  bus_in,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic        ring_enable,
  output logic [1:0]  ring_mode,
  output logic        pc_count,
  output logic        pc_load,
  output logic [15:0] jump_address,
  output logic        pc_out,
  output logic        addr_out,
  output logic        mar_in,
  output logic        ram_out,
  output logic        ram_in,
  output logic        ir_in,
  output logic        a_in,
  output logic        a_out,
  output logic        b_in,
  output logic        alu_out,
  output logic        alu_sub,
  output logic        out_in,
  output logic        halted
);

  logic [7:0]      ir_q, ir_d;
  logic [7:0]      addr_lo_q, addr_lo_d;
  logic [7:0]      addr_hi_q, addr_hi_d;
  logic            halted_q, halted_d;
  logic            carry_q, zero_q;
  logic [CW_W-1:0] cw_raw, cw;
  ring_mode_e      mode;
  logic            unused_bits;

  ctrl_step_decode u_decode (
    .opcode_i  (ir_q[7:4]),
    .t_state_i (t_state),
    .carry_i   (carry_q),
    .zero_i    (zero_q),
    .cw_o      (cw_raw),
    .mode_o    (mode)
  );

  // Controls are live only when running, out of reset and on a clean step
  always_comb begin
    cw = '0;
    if (clear_n && !halted_q && is_onehot(t_state)) cw = cw_raw;
  end

  // Next-state for instruction, address and halt registers
  always_comb begin
    ir_d      = cw[CW_IR_IN] ? bus_in : ir_q;
    addr_lo_d = cw[CW_LD_LO] ? bus_in : addr_lo_q;
    addr_hi_d = cw[CW_LD_HI] ? bus_in : addr_hi_q;
    halted_d  = halted_q | cw[CW_HALT];
  end

  // Instruction, address and halt registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ir_q      <= '0;
      addr_lo_q <= '0;
      addr_hi_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      addr_lo_q <= addr_lo_d;
      addr_hi_q <= addr_hi_d;
      halted_q  <= halted_d;
    end
  end

`ifdef CTRL_FLAGS_EN
  logic carry_d, zero_d;

  // Flag next-state: captured only on the ADD/SUB write-back step
  always_comb begin
    carry_d = cw[CW_LD_FLAGS] ? alu_carry : carry_q;
    zero_d  = cw[CW_LD_FLAGS] ? alu_zero  : zero_q;
  end

  // ALU flag registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign unused_bits = |ir_q[3:0];
`else
  assign carry_q     = 1'b0;
  assign zero_q      = 1'b0;
  assign unused_bits = |{ir_q[3:0], cw[CW_LD_FLAGS], alu_carry, alu_zero};
`endif

  assign ring_mode    = mode;
  assign ring_enable  = !halted_q;
  assign halted       = halted_q;
  assign jump_address = {addr_hi_q, addr_lo_q};
  assign pc_out       = cw[CW_PC_OUT];
  assign addr_out     = cw[CW_ADDR_OUT];
  assign mar_in       = cw[CW_MAR_IN];
  assign ram_out      = cw[CW_RAM_OUT];
  assign ram_in       = cw[CW_RAM_IN];
  assign ir_in        = cw[CW_IR_IN];
  assign a_in         = cw[CW_A_IN];
  assign a_out        = cw[CW_A_OUT];
  assign b_in         = cw[CW_B_IN];
  assign alu_out      = cw[CW_ALU_OUT];
  assign alu_sub      = cw[CW_ALU_SUB];
  assign out_in       = cw[CW_OUT_IN];
  assign pc_count     = cw[CW_PC_COUNT];
  assign pc_load      = cw[CW_PC_LOAD];

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer; the bench plays the ring counter.
module tb_control_sequencer;

`ifdef CTRL_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  // Bench-side packing of the 14 control lines, MSB first
  localparam logic [13:0] PCO  = 14'h2000;
  localparam logic [13:0] ADRO = 14'h1000;
  localparam logic [13:0] MARI = 14'h0800;
  localparam logic [13:0] RO   = 14'h0400;
  localparam logic [13:0] RAMI = 14'h0200;
  localparam logic [13:0] IRI  = 14'h0100;
  localparam logic [13:0] AI   = 14'h0080;
  localparam logic [13:0] AO   = 14'h0040;
  localparam logic [13:0] BI   = 14'h0020;
  localparam logic [13:0] ALUO = 14'h0010;
  localparam logic [13:0] SUBL = 14'h0008;
  localparam logic [13:0] OUTI = 14'h0004;
  localparam logic [13:0] PCC  = 14'h0002;
  localparam logic [13:0] PCL  = 14'h0001;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic [14:0] t_state = 15'h0001;
  logic [7:0]  bus_in = '0;
  logic        alu_carry = 1'b0, alu_zero = 1'b0;
  logic        ring_enable, pc_count, pc_load, halted;
  logic [1:0]  ring_mode;
  logic [15:0] jump_address;
  logic        pc_out, addr_out, mar_in, ram_out, ram_in, ir_in;
  logic        a_in, a_out, b_in, alu_out, alu_sub, out_in;
  logic [13:0] act_ctrl;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clear_n(clear_n), .t_state(t_state), .bus_in(bus_in),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .ring_enable(ring_enable),
    .ring_mode(ring_mode), .pc_count(pc_count), .pc_load(pc_load),
    .jump_address(jump_address), .pc_out(pc_out), .addr_out(addr_out),
    .mar_in(mar_in), .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
    .alu_sub(alu_sub), .out_in(out_in), .halted(halted)
  );

  assign act_ctrl = {pc_out, addr_out, mar_in, ram_out, ram_in, ir_in,
                     a_in, a_out, b_in, alu_out, alu_sub, out_in,
                     pc_count, pc_load};

  typedef struct {
    logic [14:0] ts;
    logic [7:0]  bus;
    logic        c, z, rn;
    logic [13:0] ctrl;
    logic [1:0]  mode;
    logic        h;
    logic [15:0] ja;
  } vec_t;

  vec_t rows[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic logic [14:0] T(input int unsigned i);
    return 15'(1) << i;
  endfunction

  task automatic add(input logic [14:0] ts, input logic [7:0] bus,
                     input logic c, input logic z, input logic rn,
                     input logic [13:0] ctrl, input logic [1:0] mode,
                     input logic h, input logic [15:0] ja);
    vec_t v;
    v.ts = ts; v.bus = bus; v.c = c; v.z = z; v.rn = rn;
    v.ctrl = ctrl; v.mode = mode; v.h = h; v.ja = ja;
    rows.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic run_rows(input int unsigned first, input int unsigned last);
    vec_t e;
    for (int unsigned i = first; i < last; i++) begin
      @(posedge clk); #1;
      t_state = rows[i].ts; bus_in = rows[i].bus;
      alu_carry = rows[i].c; alu_zero = rows[i].z; clear_n = rows[i].rn;
      sb.push_back(rows[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("row%0d ctrl", i), 16'(act_ctrl), 16'(e.ctrl));
      check($sformatf("row%0d mode", i), 16'(ring_mode), 16'(e.mode));
      check($sformatf("row%0d halted", i), 16'(halted), 16'(e.h));
      check($sformatf("row%0d ring_en", i), 16'(ring_enable), 16'(!e.h));
      check($sformatf("row%0d jaddr", i), jump_address, e.ja);
    end
  endtask

  initial begin
    logic [1:0]  m2f;
    logic [15:0] jz_ja, pre_sta;
    int unsigned split;
    m2f = FL ? 2'b10 : 2'b00;

    // Reset, then bad steps
    add(T(0), 8'h00, 0, 0, 0, '0, 2'b00, 0, 16'h0000);
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, 2'b00, 0, 16'h0000);
    add(15'h0003, 8'hFF, 0, 0, 1, '0, 2'b00, 0, 16'h0000);
    add(15'h0000, 8'hFF, 0, 0, 1, '0, 2'b00, 0, 16'h0000);
    // LDI 0x2A
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, 2'b00, 0, 16'h0000);
    add(T(1), 8'h50, 0, 0, 1, RO|IRI|PCC, 2'b00, 0, 16'h0000);
    add(T(2), 8'h00, 0, 0, 1, PCO|MARI, 2'b01, 0, 16'h0000);
    add(T(3), 8'h2A, 0, 0, 1, RO|AI|PCC, 2'b01, 0, 16'h0000);
    for (int unsigned i = 4; i < 10; i++)
      add(T(i), 8'h00, 0, 0, 1, '0, 2'b01, 0, 16'h0000);
    // ADD 0x1234 with carry
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, 2'b01, 0, 16'h0000);
    add(T(1), 8'h20, 0, 0, 1, RO|IRI|PCC, 2'b01, 0, 16'h0000);
    add(T(2), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, 16'h0000);
    add(T(3), 8'h34, 0, 0, 1, RO|PCC, 2'b10, 0, 16'h0000);
    add(T(4), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, 16'h0034);
    add(T(5), 8'h12, 0, 0, 1, RO|PCC, 2'b10, 0, 16'h0034);
    add(T(6), 8'h00, 0, 0, 1, ADRO|MARI, 2'b10, 0, 16'h1234);
    add(T(7), 8'h00, 0, 0, 1, RO|BI, 2'b10, 0, 16'h1234);
    add(T(8), 8'h00, 1, 0, 1, ALUO|AI, 2'b10, 0, 16'h1234);
    for (int unsigned i = 9; i < 15; i++)
      add(T(i), 8'h00, 0, 0, 1, '0, 2'b10, 0, 16'h1234);
    // JZ 0xBEEF (not taken) then JC 0xBEEF (taken when flags exist)
    jz_ja = FL ? 16'hBEEF : 16'h1234;
    for (int unsigned k = 0; k < 2; k++) begin
      add(T(0), 8'h00, 0, 0, 1, PCO|MARI, (k == 0) ? 2'b10 : m2f, 0,
          (k == 0) ? 16'h1234 : jz_ja);
      add(T(1), (k == 0) ? 8'h80 : 8'h70, 0, 0, 1, RO|IRI|PCC,
          (k == 0) ? 2'b10 : m2f, 0, (k == 0) ? 16'h1234 : jz_ja);
      if (FL) begin
        add(T(2), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, (k == 0) ? 16'h1234 : 16'hBEEF);
        add(T(3), 8'hEF, 0, 0, 1, RO|PCC, 2'b10, 0, (k == 0) ? 16'h1234 : 16'hBEEF);
        add(T(4), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, (k == 0) ? 16'h12EF : 16'hBEEF);
        add(T(5), 8'hBE, 0, 0, 1, RO|PCC, 2'b10, 0, (k == 0) ? 16'h12EF : 16'hBEEF);
        add(T(6), 8'h00, 0, 0, 1, (k == 0) ? 14'h0 : PCL, 2'b10, 0, 16'hBEEF);
        for (int unsigned i = 7; i < 15; i++)
          add(T(i), 8'h00, 0, 0, 1, '0, 2'b10, 0, 16'hBEEF);
      end else begin
        add(T(2), 8'h00, 0, 0, 1, '0, 2'b00, 0, 16'h1234);
        add(T(3), 8'hEF, 0, 0, 1, '0, 2'b00, 0, 16'h1234);
        add(T(4), 8'h00, 0, 0, 1, '0, 2'b00, 0, 16'h1234);
        add(T(5), 8'hBE, 0, 0, 1, '0, 2'b00, 0, 16'h1234);
      end
    end
    // STA 0x2211 up to T7
    pre_sta = FL ? 16'hBEEF : 16'h1234;
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, m2f, 0, pre_sta);
    add(T(1), 8'h40, 0, 0, 1, RO|IRI|PCC, m2f, 0, pre_sta);
    add(T(2), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, pre_sta);
    add(T(3), 8'h11, 0, 0, 1, RO|PCC, 2'b10, 0, pre_sta);
    add(T(4), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, {pre_sta[15:8], 8'h11});
    add(T(5), 8'h22, 0, 0, 1, RO|PCC, 2'b10, 0, {pre_sta[15:8], 8'h11});
    add(T(6), 8'h00, 0, 0, 1, ADRO|MARI, 2'b10, 0, 16'h2211);
    add(T(7), 8'h00, 0, 0, 1, AO|RAMI, 2'b10, 0, 16'h2211);
    split = rows.size();

    // After mid-instruction reset: JC with cleared carry must not load
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, 2'b00, 0, 16'h0000);
    add(T(1), 8'h70, 0, 0, 1, RO|IRI|PCC, 2'b00, 0, 16'h0000);
    if (FL) begin
      add(T(2), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, 16'h0000);
      add(T(3), 8'h01, 0, 0, 1, RO|PCC, 2'b10, 0, 16'h0000);
      add(T(4), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, 16'h0001);
      add(T(5), 8'h02, 0, 0, 1, RO|PCC, 2'b10, 0, 16'h0001);
      add(T(6), 8'h00, 0, 0, 1, '0, 2'b10, 0, 16'h0201);
      for (int unsigned i = 7; i < 15; i++)
        add(T(i), 8'h00, 0, 0, 1, '0, 2'b10, 0, 16'h0201);
    end else begin
      for (int unsigned i = 2; i < 6; i++)
        add(T(i), 8'h01, 0, 0, 1, '0, 2'b00, 0, 16'h0000);
    end
    // SUB 0x0403
    pre_sta = FL ? 16'h0201 : 16'h0000;
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, m2f, 0, pre_sta);
    add(T(1), 8'h30, 0, 0, 1, RO|IRI|PCC, m2f, 0, pre_sta);
    add(T(2), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, pre_sta);
    add(T(3), 8'h03, 0, 0, 1, RO|PCC, 2'b10, 0, pre_sta);
    add(T(4), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, {pre_sta[15:8], 8'h03});
    add(T(5), 8'h04, 0, 0, 1, RO|PCC, 2'b10, 0, {pre_sta[15:8], 8'h03});
    add(T(6), 8'h00, 0, 0, 1, ADRO|MARI, 2'b10, 0, 16'h0403);
    add(T(7), 8'h00, 0, 0, 1, RO|BI, 2'b10, 0, 16'h0403);
    add(T(8), 8'h00, 0, 0, 1, ALUO|AI|SUBL, 2'b10, 0, 16'h0403);
    for (int unsigned i = 9; i < 15; i++)
      add(T(i), 8'h00, 0, 0, 1, '0, 2'b10, 0, 16'h0403);
    // OUT
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, 2'b10, 0, 16'h0403);
    add(T(1), 8'hE0, 0, 0, 1, RO|IRI|PCC, 2'b10, 0, 16'h0403);
    add(T(2), 8'h00, 0, 0, 1, AO|OUTI, 2'b00, 0, 16'h0403);
    for (int unsigned i = 3; i < 6; i++)
      add(T(i), 8'h00, 0, 0, 1, '0, 2'b00, 0, 16'h0403);
    // HLT, then held at T3
    add(T(0), 8'h00, 0, 0, 1, PCO|MARI, 2'b00, 0, 16'h0403);
    add(T(1), 8'hF0, 0, 0, 1, RO|IRI|PCC, 2'b00, 0, 16'h0403);
    add(T(2), 8'h00, 0, 0, 1, '0, 2'b00, 0, 16'h0403);
    for (int unsigned i = 0; i < 3; i++)
      add(T(3), 8'h55, 0, 0, 1, '0, 2'b00, 1, 16'h0403);
    add(T(0), 8'h00, 0, 0, 1, '0, 2'b00, 1, 16'h0403);

    run_rows(0, split);

    // Asynchronous reset in the middle of STA T7
    #2 clear_n = 1'b0;
    #1;
    check("midrst ram_in", 16'(ram_in), 16'h0000);
    check("midrst ctrl", 16'(act_ctrl), 16'h0000);
    check("midrst jaddr", jump_address, 16'h0000);
    check("midrst mode", 16'(ring_mode), 16'h0000);
    @(posedge clk); #1;
    t_state = T(0);
    clear_n = 1'b1;

    run_rows(split, rows.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
